// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side controller for the single-port data memory.
// It takes one load/store at a time from the execute stage. It converts the
// byte address to a word index and rejects misaligned or out-of-range
// accesses. It strobes the memory for a single cycle and then holds the
// response until the consumer takes it.
module mem_access_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The range limit is held at full address width.
    // Any set upper address bit therefore fails the check instead of wrapping.
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    logic [1:0]    state_q,      state_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q,   resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          mem_read_q,   mem_read_d;
    logic          mem_write_q,  mem_write_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]   mem_wdata_q,  mem_wdata_d;

    logic [AW-1:0] req_word;
    logic          req_misaligned;
    logic          req_out_of_range;
    logic          req_err;

    // Decode the incoming byte address into a word index and an error flag.
    always_comb begin
        req_word         = req_addr >> 2;
        req_misaligned   = |req_addr[1:0];
        req_out_of_range = (req_word >= DEPTH_W);
        req_err          = req_misaligned | req_out_of_range;
    end

    // Next-state logic. The strobes default low, so they are high only for
    // the single ACCESS cycle. The response fields hold their values.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        // Rejected: the memory is never touched.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_read_d  = ~req_write;
                        mem_write_d = req_write;
                        mem_addr_d  = req_word;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                // Memory read data is combinational.
                // It is valid at the edge that closes this cycle.
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = mem_read_q ? mem_rdata : 32'h0;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, with async active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Drive the outputs.
    // The strobes are also gated by rst. A reset that coincides with a clock
    // edge then never shows the memory a live write strobe.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = resp_valid_q;
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
        MemRead    = mem_read_q & ~rst;
        MemWrite   = mem_write_q & ~rst;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl.
// It contains a behavioural data memory, a reference copy of the memory
// contents, and a queue of expected responses.
module tb_mem_access_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    mem_access_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: registered write, combinational read.
    logic [31:0] tb_mem [DEPTH];
    always @(posedge clk) begin
        if (MemWrite) tb_mem[mem_addr[4:0]] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr[4:0]];

    // Strobe activity counters, sampled mid-cycle.
    int rd_cyc = 0;
    int wr_cyc = 0;
    int both_cyc = 0;
    always @(negedge clk) begin
        if (MemRead === 1'b1) rd_cyc++;
        if (MemWrite === 1'b1) wr_cyc++;
        if (MemRead === 1'b1 && MemWrite === 1'b1) both_cyc++;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Present a request until accepted, then queue the expected response.
    // On return the time is 1 ns after the accepting edge.
    task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic accepted, output time t_acc);
        exp_t        e;
        logic        er;
        logic [31:0] widx;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        accepted  = 1'b0;
        t_acc     = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk);
                accepted = 1'b1;
                t_acc    = $time;
            end else begin
                @(negedge clk);
            end
        end
        widx    = a >> 2;
        er      = (a[1:0] != 2'b00) || (widx >= DEPTH);
        e.err   = er;
        e.rdata = (er || w) ? 32'h0 : ref_mem[widx[4:0]];
        if (!er && w) ref_mem[widx[4:0]] = d;
        if (accepted) exp_q.push_back(e);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) until resp_valid is seen 1 ns after an edge.
    task automatic wait_resp(output int lat, output logic seen);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        seen = (resp_valid === 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy/vld/err/rd/wr=%b want 10000",
                     {req_ready, resp_valid, resp_err, MemRead, MemWrite});
        end
        n_cmp++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want all 0",
                     resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_store_load();
        logic acc, seen;
        time  t;
        int   lat, wr0;
        exp_t e;
        wr0 = wr_cyc;
        send_req(1'b1, 32'h14, 32'hDEAD_BEEF, acc, t);
        n_cmp++;
        if (!acc || MemWrite !== 1'b1 || MemRead !== 1'b0 || mem_addr !== 32'd5
            || mem_wdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL store_strobe: got acc=%b wr=%b rd=%b addr=%0d wdata=%h want 1 1 0 5 deadbeef",
                     acc, MemWrite, MemRead, mem_addr, mem_wdata);
        end
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || lat != 1 || resp_err !== e.err || resp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL store_resp: got seen=%b lat=%0d err=%b rdata=%h want 1 1 %b %h",
                     seen, lat, resp_err, resp_rdata, e.err, e.rdata);
        end
        step();
        n_cmp++;
        if (wr_cyc - wr0 != 1) begin
            n_bad++;
            $display("FAIL store_wr_cycles: got %0d want 1", wr_cyc - wr0);
        end
        send_req(1'b0, 32'h14, 32'h0, acc, t);
        n_cmp++;
        if (!acc || MemRead !== 1'b1 || MemWrite !== 1'b0 || mem_addr !== 32'd5) begin
            n_bad++;
            $display("FAIL load_strobe: got acc=%b rd=%b wr=%b addr=%0d want 1 1 0 5",
                     acc, MemRead, MemWrite, mem_addr);
        end
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || lat != 1 || resp_err !== e.err || resp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL load_resp: got seen=%b lat=%0d err=%b rdata=%h want 1 1 %b %h",
                     seen, lat, resp_err, resp_rdata, e.err, e.rdata);
        end
        step();
        $display("store/load 0x14: rdata=%h", e.rdata);
    endtask

    task automatic test_misaligned();
        logic acc, seen;
        time  t;
        int   lat, s0;
        exp_t e;
        s0 = rd_cyc + wr_cyc;
        send_req(1'b0, 32'h6, 32'h0, acc, t);
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!acc || !seen || lat != 0 || resp_err !== 1'b1 || resp_err !== e.err
            || resp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL misaligned_resp: got acc=%b seen=%b lat=%0d err=%b rdata=%h want 1 1 0 1 %h",
                     acc, seen, lat, resp_err, resp_rdata, e.rdata);
        end
        step();
        n_cmp++;
        if (rd_cyc + wr_cyc != s0) begin
            n_bad++;
            $display("FAIL misaligned_strobes: got %0d strobe cycles want 0", rd_cyc + wr_cyc - s0);
        end
        $display("misaligned 0x6: err=%b", e.err);
    endtask

    task automatic test_out_of_range();
        logic        acc, seen;
        time         t;
        int          lat, w0;
        exp_t        e;
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h80;
        bad_addr[1] = 32'h8000_0014;
        for (int i = 0; i < 2; i++) begin
            w0 = wr_cyc;
            send_req(1'b1, bad_addr[i], 32'h5555_5555, acc, t);
            wait_resp(lat, seen);
            e = exp_q.pop_front();
            step();
            n_cmp++;
            if (!acc || !seen || lat != 0 || resp_err !== 1'b1 || resp_rdata !== e.rdata
                || wr_cyc != w0) begin
                n_bad++;
                $display("FAIL range_reject[%0d]: got lat=%0d err=%b rdata=%h wr=%0d want 0 1 0 0",
                         i, lat, resp_err, resp_rdata, wr_cyc - w0);
            end
            $display("out-of-range store %h: err=%b", bad_addr[i], e.err);
        end
        send_req(1'b1, 32'h7C, 32'h7C7C_0031, acc, t);
        n_cmp++;
        if (!acc || MemWrite !== 1'b1 || mem_addr !== 32'd31) begin
            n_bad++;
            $display("FAIL range_last_word: got acc=%b wr=%b addr=%0d want 1 1 31", acc, MemWrite, mem_addr);
        end
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        step();
        // Read back word 31 and word 5 to show neither was clobbered.
        for (int i = 0; i < 2; i++) begin
            send_req(1'b0, (i == 0) ? 32'h7C : 32'h14, 32'h0, acc, t);
            wait_resp(lat, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || resp_err !== e.err || resp_rdata !== e.rdata) begin
                n_bad++;
                $display("FAIL range_readback[%0d]: got err=%b rdata=%h want %b %h",
                         i, resp_err, resp_rdata, e.err, e.rdata);
            end
            step();
            $display("readback %0d: rdata=%h", i, e.rdata);
        end
    endtask

    task automatic test_back_pressure();
        logic acc, seen;
        time  t;
        int   lat, s0;
        exp_t e;
        send_req(1'b1, 32'h0, 32'h0000_A5A5, acc, t);
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        step();
        resp_ready = 1'b0;
        send_req(1'b0, 32'h0, 32'h0, acc, t);
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || lat != 1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL bp_first: got seen=%b lat=%0d rdata=%h err=%b want 1 1 %h %b",
                     seen, lat, resp_rdata, resp_err, e.rdata, e.err);
        end
        s0 = rd_cyc + wr_cyc;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== e.rdata
                || resp_err !== e.err) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b rdata=%h err=%b want 1 0 %h %b",
                         c, resp_valid, req_ready, resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        n_cmp++;
        if (rd_cyc + wr_cyc != s0) begin
            n_bad++;
            $display("FAIL bp_strobes: got %0d strobe cycles want 0", rd_cyc + wr_cyc - s0);
        end
        resp_ready = 1'b1;
        step();
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        $display("back-pressure load 0x0: rdata=%h held 5 cycles", e.rdata);
    endtask

    task automatic test_reset_access();
        logic        acc, seen;
        time         t;
        int          lat;
        exp_t        e;
        logic [31:0] saved;
        send_req(1'b1, 32'h8, 32'hCAFE_0008, acc, t);
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        step();
        saved = ref_mem[2];
        send_req(1'b1, 32'h8, 32'h1234_5678, acc, t);
        n_cmp++;
        if (!acc || MemWrite !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: got acc=%b wr=%b want 1 1", acc, MemWrite);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b10000
            || {resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL rst_mid_access: got rdy/vld/err/rd/wr=%b rdata=%h addr=%h wdata=%h want 10000 0 0 0",
                     {req_ready, resp_valid, resp_err, MemRead, MemWrite}, resp_rdata, mem_addr, mem_wdata);
        end
        // The aborted store never happened and its response is discarded.
        ref_mem[2] = saved;
        exp_q.delete();
        #1;
        rst = 1'b0;
        step();
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_no_resp: got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        send_req(1'b0, 32'h8, 32'h0, acc, t);
        wait_resp(lat, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || resp_err !== e.err || resp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL rst_readback: got err=%b rdata=%h want %b %h", resp_err, resp_rdata, e.err, e.rdata);
        end
        step();
        $display("reset during store: word 2 still %h", e.rdata);
    endtask

    task automatic test_back_to_back();
        logic acc, seen;
        time  t;
        time  t_acc [4];
        int   lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send_req(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i * 17), acc, t);
            wait_resp(lat, seen);
            e = exp_q.pop_front();
            step();
        end
        for (int i = 0; i < 4; i++) begin
            send_req(1'b0, 32'(i * 4), 32'h0, acc, t_acc[i]);
            n_cmp++;
            if (!acc || MemRead !== 1'b1 || mem_addr !== 32'(i)) begin
                n_bad++;
                $display("FAIL b2b_addr[%0d]: got acc=%b rd=%b addr=%0d want 1 1 %0d",
                         i, acc, MemRead, mem_addr, i);
            end
            wait_resp(lat, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || lat != 1 || resp_err !== e.err || resp_rdata !== e.rdata) begin
                n_bad++;
                $display("FAIL b2b_resp[%0d]: got lat=%0d err=%b rdata=%h want 1 %b %h",
                         i, lat, resp_err, resp_rdata, e.err, e.rdata);
            end
            step();
            $display("b2b load %0d: rdata=%h", i, e.rdata);
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (t_acc[i] - t_acc[i-1] != 30) begin
                n_bad++;
                $display("FAIL b2b_spacing[%0d]: got %0t want 30", i, t_acc[i] - t_acc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_back_pressure();
        test_reset_access();
        test_back_to_back();
        n_cmp++;
        if (both_cyc != 0) begin
            n_bad++;
            $display("FAIL strobes_exclusive: got %0d cycles with both strobes want 0", both_cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for the single-port data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake.
- Converts byte addresses to word indices and rejects misaligned or out-of-range accesses.
- Drives MemRead/MemWrite/address/write data to the memory for exactly one cycle, captures read data, and returns a response over a valid/ready handshake.

Parameters:
- DEPTH, 32: number of 32-bit words in the data memory. Legal word indices are 0..DEPTH-1.
- AW, 32: width of the request byte address and of mem_addr.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  AW  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access was rejected.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe; memory writes on the clk edge while high.
- mem_addr  output  AW  word index to memory (Alu_ans side).
- mem_wdata  output  32  store data to memory (rt_out side).
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0.
- States:
  - IDLE:
    - req_ready=1; all memory strobes 0.
    - On an edge with req_valid=1: latch req_write, req_addr and req_wdata.
    - Error check: err = (req_addr[1:0]!=0) || ((req_addr>>2) >= DEPTH).
    - If err: go to RESP with resp_err=1 and resp_rdata=0. The memory is not touched.
    - Else: go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - req_ready=0.
    - mem_addr = latched req_addr>>2; mem_wdata = latched data.
    - MemRead = ~write, MemWrite = write. Strobes are registered and high only in this cycle.
    - At the closing edge:
      - Load: resp_rdata <= mem_rdata.
      - Store: the memory commits the write; resp_rdata <= 0.
    - Go to RESP with resp_err=0.
  - RESP:
    - req_ready=0; resp_valid=1.
    - resp_rdata and resp_err are held stable until the edge where resp_ready=1.
    - On that edge go to IDLE and clear resp_valid. resp_rdata and resp_err are not cleared.
- Latency:
  - Legal access: accepted at edge N, strobes high during cycle N..N+1, resp_valid high from edge N+1.
  - Error: resp_valid high from edge N.
- Throughput: at most one request in flight. A new request is not accepted in the cycle resp_valid drops; req_ready returns the cycle after the response handshake.
- The memory port is idle (strobes 0) in IDLE and RESP. Strobes are never both 1.
- Address shift is a logical right shift. The range check uses the full AW-bit address, so high address bits are not silently wrapped.
- Back-pressure: resp_ready=0 holds RESP indefinitely with no further memory activity.
- Reset mid-operation: rst asserted during ACCESS drops MemWrite asynchronously.
  - If rst falls before the edge, no write occurs.
  - If the edge coincides with rst, the write must not occur.
  - Pending responses are discarded.
- req_valid while not in IDLE is ignored. The requester holds req_valid until req_ready.

Test Plan:
- Store then load, DEPTH=32:
  - Stimulus: store addr 0x0000_0014 data 0xDEAD_BEEF, then load addr 0x14.
  - Required: mem_addr=5 with MemWrite=1 for one cycle; load response resp_rdata=0xDEAD_BEEF, resp_err=0, resp_valid 1 cycle after accept.
- Misaligned:
  - Stimulus: load addr 0x0000_0006.
  - Required: resp_err=1, resp_rdata=0, MemRead/MemWrite never asserted, resp_valid the cycle after accept.
- Out of range:
  - Stimulus: store addr 0x80 (word 32), then addr 0x7C (word 31).
  - Required: first gives resp_err=1 with no MemWrite; second succeeds with mem_addr=31.
- Back-pressure:
  - Stimulus: load addr 0x0, hold resp_ready=0 for 5 cycles.
  - Required: resp_valid and resp_rdata stable, req_ready=0, no strobes; completes on the resp_ready edge; req_ready=1 next cycle.
- Reset during ACCESS:
  - Stimulus: store addr 0x8 data 0x1234_5678, assert rst mid-ACCESS before the edge.
  - Required: MemWrite=0 immediately, outputs at reset values, subsequent load of 0x8 returns the prior contents.
- Back-to-back:
  - Stimulus: 4 loads at addr 0x0, 0x4, 0x8, 0xC with resp_ready=1.
  - Required: each takes 3 cycles accept-to-accept, mem_addr 0,1,2,3 in order.
